// File: rtl/sound_mix_sched.sv
// Frame-synchronous stereo mixer/scheduler: one shared multiplier walks NUM_CH sources per LRCLK frame.
// Build option: define SOUND_MIX_VOL_RAMP_EN for click-free +/-1 per-frame volume ramping.
module sound_mix_sched #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int VOL_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  input  logic                      LRCLK,
  input  logic [NUM_CH*IN_W-1:0]    CH_IN,
  input  logic                      REG_VALID,
  output logic                      REG_READY,
  input  logic [$clog2(NUM_CH)-1:0] REG_ADDR,
  input  logic [2*VOL_W-1:0]        REG_WDATA,
  output logic signed [OUT_W-1:0]   OUT_L,
  output logic signed [OUT_W-1:0]   OUT_R,
  output logic                      OUT_STB,
  output logic                      BUSY,
  output logic [1:0]                SAT,
  output logic                      OVERRUN
);

  localparam int ADDR_W = $clog2(NUM_CH);
  localparam int PROD_W = IN_W + VOL_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_CH);
  localparam logic [VOL_W-1:0] UNITY = VOL_W'(1 << (VOL_W - 1));

  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, DONE} state_t;

  typedef struct packed {
    logic             clip;
    logic [OUT_W-1:0] val;
  } sat_t;

  // Drop the gain fraction, clamp to the input range, then left-align into OUT_W.
  function automatic sat_t saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] s;
    logic signed [IN_W-1:0]  v;
    sat_t                    r;
    s = acc >>> (VOL_W - 1);
    if ((&s[ACC_W-1:IN_W-1]) || !(|s[ACC_W-1:IN_W-1])) begin
      r.clip = 1'b0;
      v      = s[IN_W-1:0];
    end else begin
      r.clip = 1'b1;
      v      = s[ACC_W-1] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    end
    r.val = OUT_W'(v) << (OUT_W - IN_W);
    return r;
  endfunction

  state_t                   state, state_nxt;
  logic [2:0]               lr_sync;
  logic                     frame;
  logic [ADDR_W-1:0]        k;
  logic signed [IN_W-1:0]   snap  [NUM_CH];
  logic [VOL_W-1:0]         vol_l [NUM_CH];
  logic [VOL_W-1:0]         vol_r [NUM_CH];
  logic [VOL_W-1:0]         eff_l [NUM_CH];
  logic [VOL_W-1:0]         eff_r [NUM_CH];
  logic signed [ACC_W-1:0]  acc_l, acc_r, acc_r_fin;
  logic [VOL_W-1:0]         mul_vol;
  logic signed [PROD_W-1:0] prod;
  logic                     last_ch, wr_fire, addr_ok;
  logic                     pend_valid;
  logic [ADDR_W-1:0]        pend_addr;
  logic [2*VOL_W-1:0]       pend_data;
  sat_t                     sat_l, sat_r;

  // Bits [1:0] synchronise LRCLK; bit 2 is the previous value for edge detect.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      lr_sync <= '0;
      frame   <= 1'b0;
    end else begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      lr_sync <= {lr_sync[1:0], LRCLK};
      frame   <= lr_sync[1] & ~lr_sync[2];
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (frame) state_nxt = MUL_L;
      MUL_L:   state_nxt = MUL_R;
      MUL_R:   state_nxt = last_ch ? DONE : MUL_L;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state != IDLE);
    REG_READY = !pend_valid;
  end

  assign last_ch   = (k == ADDR_W'(NUM_CH - 1));
  assign wr_fire   = REG_VALID && REG_READY;
  assign addr_ok   = ({1'b0, REG_ADDR} < (ADDR_W + 1)'(NUM_CH));
  assign mul_vol   = (state == MUL_R) ? eff_r[k] : eff_l[k];
  assign prod      = PROD_W'(snap[k]) * PROD_W'($signed({1'b0, mul_vol}));
  assign acc_r_fin = acc_r + ACC_W'(prod);
  assign sat_l     = saturate(acc_l);
  assign sat_r     = saturate(acc_r_fin);

  // The last MUL_R edge loads the outputs so they and OUT_STB are visible in DONE.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      k       <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
      OUT_L   <= '0;
      OUT_R   <= '0;
      SAT     <= '0;
      OUT_STB <= 1'b0;
      OVERRUN <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      OUT_STB <= 1'b0;
      if (frame && state != IDLE) OVERRUN <= 1'b1;
      case (state)
        IDLE: if (frame) begin
          for (int i = 0; i < NUM_CH; i++) snap[i] <= CH_IN[i*IN_W +: IN_W];
          acc_l <= '0;
          acc_r <= '0;
          k     <= '0;
        end
        MUL_L: acc_l <= acc_l + ACC_W'(prod);
        MUL_R: begin
          acc_r <= acc_r_fin;
          if (last_ch) begin
            OUT_L   <= sat_l.val;
            OUT_R   <= sat_r.val;
            SAT     <= {sat_l.clip, sat_r.clip};
            OUT_STB <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Writes land directly outside the multiply phase; during it they wait in one pending slot.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      // NOTE: the volume file is plain flops, not RAM, so it can take a real reset value.
      for (int i = 0; i < NUM_CH; i++) begin
        vol_l[i] <= UNITY;
        vol_r[i] <= UNITY;
      end
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      if (wr_fire && addr_ok && (state == IDLE || state == DONE)) begin
        vol_l[REG_ADDR] <= REG_WDATA[2*VOL_W-1:VOL_W];
        vol_r[REG_ADDR] <= REG_WDATA[VOL_W-1:0];
      end else if (state == DONE && pend_valid) begin
        vol_l[pend_addr] <= pend_data[2*VOL_W-1:VOL_W];
        vol_r[pend_addr] <= pend_data[VOL_W-1:0];
      end
      if (wr_fire && addr_ok && (state == MUL_L || state == MUL_R)) begin
        pend_valid <= 1'b1;
        pend_addr  <= REG_ADDR;
        pend_data  <= REG_WDATA;
      end else if (state == DONE) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef SOUND_MIX_VOL_RAMP_EN
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        eff_l[i] <= UNITY;
        eff_r[i] <= UNITY;
      end
    end else if (state == DONE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (eff_l[i] < vol_l[i])      eff_l[i] <= eff_l[i] + 1'b1;
        else if (eff_l[i] > vol_l[i]) eff_l[i] <= eff_l[i] - 1'b1;
        if (eff_r[i] < vol_r[i])      eff_r[i] <= eff_r[i] + 1'b1;
        else if (eff_r[i] > vol_r[i]) eff_r[i] <= eff_r[i] - 1'b1;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eff_l[i] = vol_l[i];
      eff_r[i] = vol_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_sound_mix_sched.sv
// Directed + randomised bench for sound_mix_sched; expected mixes come from an integer model
// (sum of sample*volume, shift, clamp) kept entirely in the bench.
module tb_sound_mix_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrclk = 1'b0;
  logic        reg_valid = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [15:0] reg_wdata = '0;
  logic [63:0] ch_in;
  logic        reg_ready, out_stb, busy, overrun;
  logic [15:0] out_l, out_r;
  logic [1:0]  sat;

  logic signed [15:0] ch [4];
  int vl_m [4];
  int vr_m [4];
  int n_pass = 0;
  int n_total = 0;

  assign ch_in = {ch[3], ch[2], ch[1], ch[0]};

  always #5 clk = ~clk;

  sound_mix_sched #(.NUM_CH(4), .IN_W(16), .VOL_W(8), .OUT_W(16)) dut (
    .CLK(clk), .RESET_n(rst_n), .LRCLK(lrclk), .CH_IN(ch_in),
    .REG_VALID(reg_valid), .REG_READY(reg_ready), .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata),
    .OUT_L(out_l), .OUT_R(out_r), .OUT_STB(out_stb), .BUSY(busy), .SAT(sat), .OVERRUN(overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] clamp16(input longint x);
    logic [15:0] r;
    if (x > 32767)       r = 16'h7fff;
    else if (x < -32768) r = 16'h8000;
    else                 r = 16'(x);
    return r;
  endfunction

  // Gain is vol/128: exact integer sum, floor-divide by 128, clamp to 16-bit signed.
  function automatic void model(output logic [15:0] l, output logic [15:0] r, output logic [1:0] s);
    longint al = 0;
    longint ar = 0;
    for (int i = 0; i < 4; i++) begin
      al += longint'(ch[i]) * vl_m[i];
      ar += longint'(ch[i]) * vr_m[i];
    end
    al = al >>> 7;
    ar = ar >>> 7;
    s = {(al > 32767 || al < -32768), (ar > 32767 || ar < -32768)};
    l = clamp16(al);
    r = clamp16(ar);
  endfunction

  task automatic reg_write(input int a, input int vl, input int vr);
    int w = 0;
    @(negedge clk);
    reg_valid = 1'b1;
    reg_addr  = 2'(a);
    reg_wdata = {8'(vl), 8'(vr)};
    while (reg_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("wr_accept", 32'(w < 40), 32'd1);
    @(negedge clk);
    reg_valid = 1'b0;
    vl_m[a] = vl;
    vr_m[a] = vr;
  endtask

  // Raise LRCLK, wait for the strobe, check latency, mix, pulse width and hold.
  task automatic run_frame(input string tag);
    logic [15:0] el, er;
    logic [1:0]  es;
    int cnt = 0;
    model(el, er, es);
    @(negedge clk);
    lrclk = 1'b1;
    while (out_stb !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 6) lrclk = 1'b0;
    end
    lrclk = 1'b0;
    check({tag, "_lat"}, cnt, 12);
    check({tag, "_l"}, out_l, el);
    check({tag, "_r"}, out_r, er);
    check({tag, "_sat"}, sat, es);
    @(negedge clk);
    check({tag, "_stb_pulse"}, out_stb, 1'b0);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, {out_l, out_r}, {el, er});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] el, er;
    logic [1:0]  es;
    int cnt, stb_n, stb_at;

    for (int i = 0; i < 4; i++) begin
      ch[i]   = '0;
      vl_m[i] = 128;
      vr_m[i] = 128;
    end
    repeat (3) @(negedge clk);
    check("rst_out_l", out_l, 16'h0);
    check("rst_out_r", out_r, 16'h0);
    check("rst_stb", out_stb, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sat", sat, 2'b00);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ready", reg_ready, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    ch[0] = 16'h1234;
    run_frame("unity");
    check("unity_const", {out_l, out_r, 14'h0, sat}, {16'h1234, 16'h1234, 16'h0000});

    reg_write(0, 'h40, 'h00);
    ch[0] = 16'h2000;
    run_frame("half");
    check("half_const", {out_l, out_r}, {16'h1000, 16'h0000});

    reg_write(0, 'h80, 'h80);
    for (int i = 0; i < 4; i++) ch[i] = 16'h7000;
    run_frame("satp");
    check("satp_const", {out_l, out_r, 14'h0, sat}, {16'h7fff, 16'h7fff, 16'h0003});
    for (int i = 0; i < 4; i++) ch[i] = 16'h9000;
    run_frame("satn");
    check("satn_const", {out_l, out_r, 14'h0, sat}, {16'h8000, 16'h8000, 16'h0003});

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) ch[i] = 16'($urandom);
      if (n[0]) for (int i = 0; i < 4; i++) ch[i] = ch[i] >>> 2;
      reg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      run_frame("rnd");
    end

    // Volume writes while busy: pending slot, READY low until DONE, second write stalls.
    ch[0] = 16'h1000;
    ch[1] = 16'h0100;
    ch[2] = 16'h0000;
    ch[3] = 16'h0000;
    model(el, er, es);
    @(negedge clk);
    lrclk = 1'b1;
    cnt = 0;
    stb_at = 0;
    repeat (20) begin
      @(negedge clk);
      cnt++;
      if (out_stb === 1'b1 && stb_at == 0) stb_at = cnt;
      case (cnt)
        6: begin
          lrclk = 1'b0;
          check("wr_ready_free", reg_ready, 1'b1);
          reg_valid = 1'b1;
          reg_addr  = 2'd0;
          reg_wdata = 16'h4040;
        end
        7: begin
          check("wr_ready_drop", reg_ready, 1'b0);
          reg_addr  = 2'd1;
          reg_wdata = 16'h2060;
        end
        12: begin
          check("wr_ready_held", reg_ready, 1'b0);
          check("wr_old_vol", {out_l, out_r}, {el, er});
        end
        13: check("wr_ready_back", reg_ready, 1'b1);
        14: reg_valid = 1'b0;
        default: ;
      endcase
    end
    check("wr_lat", stb_at, 12);
    vl_m[0] = 'h40;
    vr_m[0] = 'h40;
    vl_m[1] = 'h20;
    vr_m[1] = 'h60;
    run_frame("wr_new");

    // Second LRCLK edge 4 cycles after the first lands while busy.
    for (int i = 0; i < 4; i++) ch[i] = 16'($urandom) >>> 3;
    model(el, er, es);
    @(negedge clk);
    lrclk = 1'b1;
    cnt = 0;
    stb_n = 0;
    stb_at = 0;
    repeat (30) begin
      @(negedge clk);
      cnt++;
      if (out_stb === 1'b1) begin
        stb_n++;
        if (stb_at == 0) stb_at = cnt;
      end
      if (cnt == 2) lrclk = 1'b0;
      if (cnt == 4) lrclk = 1'b1;
      if (cnt == 6) lrclk = 1'b0;
    end
    check("ovr_stb_count", stb_n, 1);
    check("ovr_lat", stb_at, 12);
    check("ovr_mix", {out_l, out_r}, {el, er});
    check("ovr_flag", overrun, 1'b1);
    run_frame("ovr_next");
    check("ovr_sticky", overrun, 1'b1);

    // Reset pulsed while the FSM is in MUL_R.
    @(negedge clk);
    lrclk = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    lrclk = 1'b0;
    #1;
    check("rst_mid_out", {out_l, out_r}, 32'h0);
    check("rst_mid_flags", {busy, overrun, out_stb, sat, reg_ready}, 6'b000001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vl_m[i] = 128;
      vr_m[i] = 128;
      ch[i]   = 16'($urandom) >>> 2;
    end
    repeat (2) @(negedge clk);
    run_frame("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
